// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_cmd_sequencer: buffers ALU commands in a FIFO and issues them on the  |
// | start/done port; optional watchdog enabled by ALU_SEQ_TIMEOUT_EN.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [18:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          alu_start_q, alu_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic          rsp_err_q, rsp_err_d;

  logic          fifo_full, fifo_empty, push, pop, tmo_hit;
  logic [18:0]   head;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = reset_n && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  // rsp_valid is the registered value, so a response drained this cycle delays issue by one
  assign pop        = (state_q == IDLE) && !fifo_empty && !rsp_valid_q;
  assign head       = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == ISSUE) && (tmo_cnt_q == TW'(TIMEOUT));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ISSUE) begin
      tmo_cnt_d = '0;
    end else if (!alu_done && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = alu_start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          alu_op_d = head[18:16];
          alu_a_d  = head[15:8];
          alu_b_d  = head[7:0];
          if (head[18:16] != 3'b000) begin
            alu_start_d = 1'b1;
            state_d     = ISSUE;
          end else begin
            // the ALU never answers a no-op, so respond locally
            rsp_result_d = 16'h0000;
            rsp_op_d     = 3'b000;
            rsp_err_d    = 1'b0;
            rsp_valid_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
          state_d      = GAP;
        end else if (tmo_hit) begin
          rsp_result_d = 16'h0000;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
          state_d      = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_cmd_sequencer: stub ALU, response scoreboard and timing vectors.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b, alu_A, alu_B;
  logic [2:0]  cmd_op, alu_op, rsp_op;
  logic        alu_start, alu_done, rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] alu_result, rsp_result;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  logic [15:0] last_res = '0;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  op;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'b000:  return 16'h0000;
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      default: return 16'(a) * 16'(b);
    endcase
  endfunction

  function automatic int alu_lat(logic [2:0] op);
    if (op == 3'b000) return 0;
`ifdef ALU_SEQ_TIMEOUT_EN
    if (op == 3'b101) return 0;
`endif
    if (op[2]) return 4;
    return 1;
  endfunction

  function automatic exp_t predict(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    exp_t e;
    e.res = alu_fn(a, b, op);
    e.op  = op;
    e.err = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    if (op == 3'b101) begin
      e.res = 16'h0000;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  // Stub ALU: done after the op latency, stays up one cycle past start falling
  int alu_cnt = 0;
  always @(posedge clk) begin
    if (!reset_n || !alu_start) begin
      alu_cnt  <= 0;
      alu_done <= 1'b0;
    end else begin
      alu_cnt <= alu_cnt + 1;
      if (alu_lat(alu_op) != 0 && alu_cnt + 1 >= alu_lat(alu_op)) begin
        alu_done   <= 1'b1;
        alu_result <= alu_fn(alu_A, alu_B, alu_op);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) exp_q.push_back(predict(cmd_a, cmd_b, cmd_op));
    if (reset_n && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      last_res = rsp_result;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got result %0h op %0h, expected no response", rsp_result, rsp_op);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_result", rsp_result, mon_e.res);
        check("rsp_op", rsp_op, mon_e.op);
        check("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = !busy && !rsp_valid;
      @(posedge clk); #1;
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200 && rsp_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    check("rsp_arrived", rsp_cnt >= target, 1);
  endtask

  // Record alu_start / rsp_valid per cycle index, and count start cycles with operands == key
  task automatic sample(input int first, input int last, input logic [18:0] key,
                        output logic [15:0] sm, output logic [15:0] rm, output int stab);
    sm = '0; rm = '0; stab = 0;
    for (int c = first; c <= last; c++) begin
      @(negedge clk);
      sm[c] = alu_start;
      rm[c] = rsp_valid;
      if (alu_start && {alu_op, alu_A, alu_B} == key) stab++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sm, rm;
    int stab, base, hi;
    bit hi_done;
    logic [2:0] bp_ops[6];

    tbl[0] = '{8'h7F, 8'h81, 3'b001, 16'h0100};
    tbl[1] = '{8'hFF, 8'hFF, 3'b001, 16'h01FE};
    tbl[2] = '{8'h00, 8'h00, 3'b001, 16'h0000};
    tbl[3] = '{8'hF0, 8'h3C, 3'b010, 16'h0030};
    tbl[4] = '{8'hF0, 8'h3C, 3'b011, 16'h00CC};
    tbl[5] = '{8'hFF, 8'hFF, 3'b100, 16'hFE01};
    tbl[6] = '{8'h12, 8'h34, 3'b111, 16'h03A8};
    tbl[7] = '{8'h00, 8'h55, 3'b110, 16'h0000};
    tbl[8] = '{8'h80, 8'h02, 3'b110, 16'h0100};
    tbl[9] = '{8'hAB, 8'hCD, 3'b000, 16'h0000};
    bp_ops = '{3'b001, 3'b100, 3'b000, 3'b011, 3'b110, 3'b010};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_alu_start", alu_start, 0);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_alu_ops", {alu_op, alu_A, alu_B}, 0);
    check("reset_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Add timing: start cycles 2-3, response cycle 4
    wait_idle();
    send(8'h7F, 8'h81, 3'b001);
    sample(1, 8, {3'b001, 8'h7F, 8'h81}, sm, rm, stab);
    check("add_start_cycles", sm, 16'h000C);
    check("add_rsp_cycles", rm, 16'h0010);
    check("add_result", last_res, 16'h0100);

    // Multiply: start held cycles 2-6 with stable operands, response cycle 7
    wait_idle();
    send(8'hFF, 8'hFF, 3'b100);
    sample(1, 9, {3'b100, 8'hFF, 8'hFF}, sm, rm, stab);
    check("mul_start_cycles", sm, 16'h007C);
    check("mul_rsp_cycles", rm, 16'h0080);
    check("mul_operands_stable", stab, 5);
    check("mul_result", last_res, 16'hFE01);

    // No-op then xor: no start for the no-op, xor issues after the no-op response drains
    wait_idle();
    send(8'hAB, 8'hCD, 3'b000);
    send(8'hF0, 8'h3C, 3'b011);
    sample(2, 10, {3'b011, 8'hF0, 8'h3C}, sm, rm, stab);
    check("noop_xor_start_cycles", sm, 16'h0030);
    check("noop_xor_rsp_cycles", rm, 16'h0044);
    check("xor_result", last_res, 16'h00CC);

    // Back-to-back single-cycle ops: one issue per 4 cycles
    wait_idle();
    send(8'h01, 8'h02, 3'b001);
    send(8'h10, 8'h20, 3'b001);
    sample(2, 10, {3'b001, 8'h10, 8'h20}, sm, rm, stab);
    check("b2b_start_cycles", sm, 16'h00CC);
    check("b2b_rsp_cycles", rm, 16'h0110);
    check("b2b_result", last_res, 16'h0030);

    // Table-driven single commands
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      base = rsp_cnt;
      send(tbl[i].a, tbl[i].b, tbl[i].op);
      wait_rsp(base + 1);
      check($sformatf("tbl%0d_result", i), last_res, tbl[i].res);
    end

    // Back-pressure: 1 issued + 4 buffered, then cmd_ready drops
    wait_idle();
    rsp_ready = 1'b0;
    base = rsp_cnt;
    for (int i = 0; i < 5; i++) send(8'(i * 17 + 3), 8'(i * 29 + 5), bp_ops[i]);
    repeat (4) begin
      @(negedge clk);
      check("bp_cmd_ready_low", cmd_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_outstanding", exp_q.size(), 5);
    check("bp_no_drain", rsp_cnt - base, 0);
    rsp_ready = 1'b1;
    send(8'h5A, 8'hA5, bp_ops[5]);
    wait_rsp(base + 6);
    check("bp_drained", rsp_cnt - base, 6);
    check("bp_queue_empty", exp_q.size(), 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Watchdog: op 101 never completes on the stub ALU
    wait_idle();
    base = rsp_cnt;
    send(8'h12, 8'h34, 3'b101);
    hi = 0; hi_done = 1'b0;
    for (int c = 0; c < 80 && !hi_done; c++) begin
      @(negedge clk);
      if (alu_start) hi++;
      else if (hi > 0) hi_done = 1'b1;
      @(posedge clk); #1;
    end
    check("tmo_start_cycles", hi, 16);
    wait_rsp(base + 1);
    check("tmo_result", last_res, 16'h0000);
    wait_idle();
    base = rsp_cnt;
    send(8'h05, 8'h06, 3'b001);
    wait_rsp(base + 1);
    check("tmo_next_result", last_res, 16'h000B);
`endif

    // Reset in cycle 4 of a multiply: command dropped, no response
    wait_idle();
    base = rsp_cnt;
    send(8'h0F, 8'h0F, 3'b100);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_cmd_ready_forced", cmd_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_alu_start", alu_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_ops", {alu_op, alu_A, alu_B}, 0);
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_rsp", rsp_cnt - base, 0);

    wait_idle();
    base = rsp_cnt;
    send(8'h21, 8'h12, 3'b011);
    wait_rsp(base + 1);
    check("rst_recover_result", last_res, 16'h0033);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the tiny ALU. Buffers operand/opcode commands from a valid/ready source in a small FIFO and issues them one at a time on the ALU's start/done interface. It holds operands and start stable until done, then captures the ALU result into a single-entry response register with its own valid/ready handshake. It hides the ALU's variable latency (single-cycle vs. multi-cycle ops) and the no-op case, where the ALU never returns done, from the command source.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- TIMEOUT, 15: watchdog limit in cycles; used only with ALU_SEQ_TIMEOUT_EN.

- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full, forced 0 while reset_n=0.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  3  opcode. 000 no-op, 001 add, 010 and, 011 xor, 1xx multiply.
- alu_A  out  8  registered operand to ALU.
- alu_B  out  8  registered operand to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_start  out  1  registered start to ALU.
- alu_done  in  1  ALU completion.
- alu_result  in  16  ALU result, valid when alu_done=1.
- rsp_valid  out  1  response register full.
- rsp_ready  in  1  response consumer accepts.
- rsp_result  out  16  captured result.
- rsp_op  out  3  opcode of the captured command.
- rsp_err  out  1  timeout flag; constant 0 without the macro.
- busy  out  1  high when state≠IDLE or FIFO non-empty.

## Operation
- FIFO: push when cmd_valid && cmd_ready. Pop only by the FSM in IDLE. cmd_ready is not raised by a same-cycle pop. Pointers wrap modulo DEPTH; a count of DEPTH+1 values distinguishes full from empty.
- FSM states: IDLE, ISSUE, GAP.
- IDLE: if FIFO non-empty and rsp_valid=0, pop the head and load alu_A/alu_B/alu_op.
  - op≠000: set alu_start=1 and go to ISSUE.
  - op=000: do not start the ALU. Load rsp_result=16'h0000, rsp_op=000, rsp_err=0, rsp_valid=1. Stay in IDLE.
- ISSUE: alu_start, alu_A, alu_B and alu_op are held constant.
  - When alu_done=1: capture alu_result into rsp_result, set rsp_op and rsp_valid=1, rsp_err=0. Then alu_start←0 and go to GAP.
- GAP: one cycle with alu_start=0. alu_done is ignored, because the ALU's done is still high for one cycle after start drops. Then go to IDLE.
- Response: rsp_valid clears on the cycle rsp_valid && rsp_ready. rsp_result, rsp_op and rsp_err are stable while rsp_valid=1.
- Simultaneous rsp pop and IDLE issue: IDLE sees rsp_valid as registered, so issue waits one cycle.
- Reset (at any time, including mid-operation): FIFO emptied; state IDLE; alu_start, alu_A, alu_B, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err all 0; busy 0. A command in flight is dropped with no response.

## Timing
- Cycle 0: push into an empty FIFO. Sequencer is idle and rsp_valid=0.
- Cycle 1: IDLE pops the command.
- Cycle 2: alu_start=1 with operands valid.
- Single-cycle op (001–011): alu_done at cycle 3, rsp_valid at cycle 4, GAP at cycle 4, IDLE at cycle 5.
- Multiply (1xx): alu_done at cycle 6 (start+4), rsp_valid at cycle 7.
- No-op: rsp_valid at cycle 2.
- Back-to-back throughput once responses are consumed immediately:
  - single-cycle ops: one per 4 cycles (the response must drain before the next issue).
  - multiply: one per 7 cycles.
- alu_start rises at most once per command and stays high continuously until done (or timeout).

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - A counter is cleared on ISSUE entry and increments each ISSUE cycle without done.
  - On the cycle count=TIMEOUT with alu_done=0, treat it as done: rsp_result=16'h0000, rsp_err=1, rsp_valid=1, alu_start←0, go to GAP.
  - A done arriving in the same cycle as the timeout wins: normal capture, rsp_err=0.
- ALU_SEQ_TIMEOUT_EN undefined: no counter. ISSUE waits indefinitely. rsp_err is tied to 0.

## Test plan
- Add A=0x7F, B=0x81, op=001:
  - alu_start high cycles 2–3, done sampled at cycle 3.
  - rsp_valid at cycle 4 with rsp_result=0x0100, rsp_op=001.
- Multiply A=0xFF, B=0xFF, op=100:
  - alu_start held high for 5 cycles, operands stable throughout.
  - rsp_result=0xFE01 at cycle 7.
- No-op op=000 followed by xor 0xF0^0x3C:
  - alu_start never pulses for the no-op; the no-op yields rsp_result=0x0000.
  - With rsp_ready=1, the xor response is 0x00CC.
- Back-pressure: hold rsp_ready=0 and push 6 commands.
  - cmd_ready drops after 1 issued + 4 buffered.
  - Releasing rsp_ready drains all responses in order with no loss or duplication.
- With the macro and TIMEOUT=15: a stub ALU never asserts done for op=101.
  - alu_start high exactly 16 cycles.
  - Response has rsp_err=1, rsp_result=0.
  - The next command then completes normally.
- Reset: assert reset_n=0 at cycle 4 of a multiply.
  - Next cycle: alu_start=0, rsp_valid=0, FIFO empty.
  - No response is produced for the aborted command.
